// File: rtl/reaction_score_keeper_pkg.sv
// Shared definitions for the reaction score keeper and the display path.
//
// Contents:
//   state_t     - control states of the score keeper (IDLE, RUN, DONE)
//   BLANK_CODE  - display code for an empty digit
//   CHAR_*      - letter codes understood by the seven-segment decoder
//   digit_code  - turns a BCD digit into its 5-bit display code
package reaction_score_keeper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Display codes shared with the seven-segment decoder. Codes 0-9 are the
  // decimal digits themselves; everything above 9 is a glyph.
  localparam logic [4:0] BLANK_CODE = 5'd30;
  localparam logic [4:0] CHAR_L     = 5'd24;
  localparam logic [4:0] CHAR_I     = 5'd23;
  localparam logic [4:0] CHAR_A     = 5'd22;
  localparam logic [4:0] CHAR_F     = 5'd21;
  localparam logic [4:0] CHAR_E     = 5'd27;
  localparam logic [4:0] CHAR_D     = 5'd28;

  // Width of the millisecond prescaler (CYCLES_PER_MS is at most 65535).
  localparam int unsigned PRESCALE_W = 16;

  // A decimal digit is displayed as its own value with the glyph bit clear.
  function automatic logic [4:0] digit_code(input logic [3:0] digit);
    return {1'b0, digit};
  endfunction

endpackage

// File: rtl/reaction_score_keeper_bcd_digit_counter.sv
// bcd_digit_counter: one decimal digit of the live reaction-time counter.
//
// Ports:
//   clk     in  1  counter clock
//   reset   in  1  asynchronous active-low reset, digit -> 0
//   clear   in  1  synchronous clear, wins over enable
//   enable  in  1  advance the digit by one this cycle
//   hold    in  1  saturate: ignore enable (whole counter sits at 9999)
//   digit   out 4  current digit value 0-9
//   carry   out 1  digit is 9; the next enable would roll it over
//
// The carry is the plain "at nine" condition; the parent ANDs the carries of
// all lower digits with the tick to build each digit's enable.
module bcd_digit_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       hold,
  output logic [3:0] digit,
  output logic       carry
);

  logic [3:0] digit_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digit_reg <= 4'd0;
    end else if (clear) begin
      digit_reg <= 4'd0;
    end else if (enable && !hold) begin
      digit_reg <= (digit_reg == 4'd9) ? 4'd0 : digit_reg + 4'd1;
    end
  end

  assign digit = digit_reg;
  assign carry = (digit_reg == 4'd9);

endmodule

// File: rtl/reaction_score_keeper.sv
// reaction_score_keeper: times the player's reaction in milliseconds with a
// 4-digit BCD counter, latches the last result and remembers the best
// (lowest) one, presenting both as display codes for the 7-segment mux.
//
// Parameters:
//   CYCLES_PER_MS  clk cycles per millisecond tick (1..65535)
//   BLANK_CODE     display code driven for an empty digit
//
// Ports:
//   clk                in  1  divided system clock
//   reset              in  1  asynchronous active-low reset
//   start              in  1  pulse: stimulus shown, begin timing
//   stop               in  1  pulse: player pressed
//   abort              in  1  pulse: early press / fail, discard run
//   clear_best         in  1  pulse: forget the best score
//   running            out 1  high while timing
//   result_valid       out 1  pulse: a new result was latched
//   new_best           out 1  pulse with result_valid when the result is best
//   timeout            out 1  last measurement saturated at 9999
//   result_d0..d3      out 5  last result digits, d0 least significant
//   best_d0..d3        out 5  best score digits, d0 least significant
module reaction_score_keeper
  import reaction_score_keeper_pkg::state_t,
         reaction_score_keeper_pkg::IDLE,
         reaction_score_keeper_pkg::RUN,
         reaction_score_keeper_pkg::DONE,
         reaction_score_keeper_pkg::PRESCALE_W,
         reaction_score_keeper_pkg::digit_code;
#(
  parameter int unsigned CYCLES_PER_MS = 1,
  parameter logic [4:0]  BLANK_CODE    = reaction_score_keeper_pkg::BLANK_CODE
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       abort,
  input  logic       clear_best,
  output logic       running,
  output logic       result_valid,
  output logic       new_best,
  output logic       timeout,
  output logic [4:0] result_d0,
  output logic [4:0] result_d1,
  output logic [4:0] result_d2,
  output logic [4:0] result_d3,
  output logic [4:0] best_d0,
  output logic [4:0] best_d1,
  output logic [4:0] best_d2,
  output logic [4:0] best_d3
);

  localparam logic [PRESCALE_W-1:0] PRESCALE_LAST = PRESCALE_W'(CYCLES_PER_MS - 1);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t state_reg;
  state_t state_next;

  logic arm;        // (re)start timing from 0000
  logic latch;      // stop accepted: capture the live count
  logic abort_run;  // run discarded
  logic counting;   // plain RUN cycle with no event: prescaler advances

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Event priority inside RUN is abort, then stop, then start (restart).
  // Outside RUN only start matters.
  always_comb begin
    state_next = state_reg;
    arm        = 1'b0;
    latch      = 1'b0;
    abort_run  = 1'b0;
    counting   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          arm        = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
          abort_run  = 1'b1;
        end else if (stop) begin
          state_next = DONE;
          latch      = 1'b1;
        end else if (start) begin
          arm = 1'b1;
        end else begin
          counting = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_next = RUN;
          arm        = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Millisecond prescaler
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] prescaler_reg;
  logic                  tick;

  // A stop on the tick cycle suppresses the tick, so the latched value is the
  // pre-increment count.
  assign tick = counting && (prescaler_reg == PRESCALE_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler_reg <= '0;
    end else if (arm) begin
      prescaler_reg <= '0;
    end else if (counting) begin
      prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Live BCD ripple counter
  // ---------------------------------------------------------------------------
  logic [3:0] live_digit [4];
  logic [3:0] carry;
  logic [3:0] digit_en;
  logic       saturated;
  logic [15:0] live_value;

  // Once every digit is 9 the whole counter freezes instead of wrapping.
  assign saturated  = &carry;
  assign live_value = {live_digit[3], live_digit[2], live_digit[1], live_digit[0]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    if (gi == 0) begin : g_lsd
      assign digit_en[gi] = tick;
    end else begin : g_upper
      assign digit_en[gi] = digit_en[gi-1] & carry[gi-1];
    end

    bcd_digit_counter u_digit (
      .clk    (clk),
      .reset  (reset),
      .clear  (arm),
      .enable (digit_en[gi]),
      .hold   (saturated),
      .digit  (live_digit[gi]),
      .carry  (carry[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Result / best bookkeeping
  // ---------------------------------------------------------------------------
  logic        timeout_reg;
  logic        result_valid_reg;
  logic        new_best_reg;
  logic        best_present_reg;
  logic [15:0] best_value_reg;
  logic        beats_best;

  // Valid BCD compares correctly as a plain binary number. A clear_best in the
  // latch cycle means there is no best to beat, so the new result takes over.
  assign beats_best = clear_best || !best_present_reg || (live_value < best_value_reg);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timeout_reg      <= 1'b0;
      result_valid_reg <= 1'b0;
      new_best_reg     <= 1'b0;
      best_present_reg <= 1'b0;
      best_value_reg   <= 16'h0000;
    end else begin
      result_valid_reg <= latch;
      new_best_reg     <= latch && beats_best;

      // Timeout rises together with the count reaching 9999.
      if (arm || abort_run) begin
        timeout_reg <= 1'b0;
      end else if (tick && live_value == 16'h9998) begin
        timeout_reg <= 1'b1;
      end

      if (latch && beats_best) begin
        best_present_reg <= 1'b1;
        best_value_reg   <= live_value;
      end else if (clear_best) begin
        best_present_reg <= 1'b0;
      end
    end
  end

  // Per-digit display registers, so the outputs come straight from flops.
  logic [3:0][4:0] result_codes;
  logic [3:0][4:0] best_codes;

  for (genvar gi = 0; gi < 4; gi++) begin : g_disp
    logic [4:0] result_code_reg;
    logic [4:0] best_code_reg;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        result_code_reg <= BLANK_CODE;
        best_code_reg   <= BLANK_CODE;
      end else begin
        if (abort_run) begin
          result_code_reg <= BLANK_CODE;
        end else if (latch) begin
          result_code_reg <= digit_code(live_digit[gi]);
        end

        if (latch && beats_best) begin
          best_code_reg <= digit_code(live_digit[gi]);
        end else if (clear_best) begin
          best_code_reg <= BLANK_CODE;
        end
      end
    end

    assign result_codes[gi] = result_code_reg;
    assign best_codes[gi]   = best_code_reg;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign running      = (state_reg == RUN);
  assign result_valid = result_valid_reg;
  assign new_best     = new_best_reg;
  assign timeout      = timeout_reg;

  assign result_d0 = result_codes[0];
  assign result_d1 = result_codes[1];
  assign result_d2 = result_codes[2];
  assign result_d3 = result_codes[3];
  assign best_d0   = best_codes[0];
  assign best_d1   = best_codes[1];
  assign best_d2   = best_codes[2];
  assign best_d3   = best_codes[3];

endmodule

// File: tb/tb_reaction_score_keeper.sv
// Bench for reaction_score_keeper. Two instances (1 and 4 cycles per ms) share
// one stimulus stream; a behavioural model that keeps times as plain integers
// predicts every output and is compared on each falling edge. Directed
// literal checks pin both the DUT and the model at the key scenarios.
module tb_reaction_score_keeper;

  localparam logic [4:0]  BL     = 5'd30;
  localparam logic [19:0] BLANK4 = {BL, BL, BL, BL};
  localparam logic [19:0] R0050  = {5'd0, 5'd0, 5'd5, 5'd0};
  localparam logic [19:0] R0250  = {5'd0, 5'd2, 5'd5, 5'd0};
  localparam logic [19:0] R0187  = {5'd0, 5'd1, 5'd8, 5'd7};
  localparam logic [19:0] R0300  = {5'd0, 5'd3, 5'd0, 5'd0};
  localparam logic [19:0] R9999  = {5'd9, 5'd9, 5'd9, 5'd9};
  localparam logic [19:0] R0010  = {5'd0, 5'd0, 5'd1, 5'd0};
  localparam logic [19:0] R0040  = {5'd0, 5'd0, 5'd4, 5'd0};
  localparam logic [19:0] R0500  = {5'd0, 5'd5, 5'd0, 5'd0};
  localparam logic [19:0] R0125  = {5'd0, 5'd1, 5'd2, 5'd5};

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, stop = 1'b0, abort = 1'b0, clear_best = 1'b0;

  logic       running_o [2];
  logic       valid_o   [2];
  logic       newbest_o [2];
  logic       timeout_o [2];
  logic [4:0] rd [2][4];
  logic [4:0] bd [2][4];

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    reaction_score_keeper #(
      .CYCLES_PER_MS (gi == 0 ? 1 : 4),
      .BLANK_CODE    (5'd30)
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stop         (stop),
      .abort        (abort),
      .clear_best   (clear_best),
      .running      (running_o[gi]),
      .result_valid (valid_o[gi]),
      .new_best     (newbest_o[gi]),
      .timeout      (timeout_o[gi]),
      .result_d0    (rd[gi][0]),
      .result_d1    (rd[gi][1]),
      .result_d2    (rd[gi][2]),
      .result_d3    (rd[gi][3]),
      .best_d0      (bd[gi][0]),
      .best_d1      (bd[gi][1]),
      .best_d2      (bd[gi][2]),
      .best_d3      (bd[gi][3])
    );
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: times in ms as integers, -1 means "nothing to show".
  // m_phase: 0 waiting for start, 1 timing, 2 showing a result.
  // ---------------------------------------------------------------------------
  int m_cpm    [2] = '{1, 4};
  int m_phase  [2] = '{0, 0};
  int m_ms     [2] = '{0, 0};
  int m_cycles [2] = '{0, 0};
  int m_result [2] = '{-1, -1};
  int m_best   [2] = '{-1, -1};
  bit m_valid  [2] = '{0, 0};
  bit m_newbest[2] = '{0, 0};
  bit m_timeout[2] = '{0, 0};

  task automatic model_reset(input int k);
    m_phase[k] = 0; m_ms[k] = 0; m_cycles[k] = 0;
    m_result[k] = -1; m_best[k] = -1;
    m_valid[k] = 0; m_newbest[k] = 0; m_timeout[k] = 0;
  endtask

  task automatic model_restart(input int k);
    m_phase[k] = 1; m_ms[k] = 0; m_cycles[k] = 0; m_timeout[k] = 0;
  endtask

  task automatic model_step(input int k);
    bit latched;
    latched = 0;
    m_valid[k] = 0;
    m_newbest[k] = 0;
    if (m_phase[k] == 1) begin
      if (abort) begin
        m_phase[k] = 0; m_result[k] = -1; m_timeout[k] = 0;
      end else if (stop) begin
        latched = 1;
        m_result[k] = m_ms[k];
        m_valid[k] = 1;
        if (clear_best || m_best[k] < 0 || m_ms[k] < m_best[k]) begin
          m_best[k] = m_ms[k];
          m_newbest[k] = 1;
        end
        m_phase[k] = 2;
      end else if (start) begin
        model_restart(k);
      end else begin
        m_cycles[k]++;
        if (m_cycles[k] == m_cpm[k]) begin
          m_cycles[k] = 0;
          if (m_ms[k] < 9999) m_ms[k]++;
        end
        if (m_ms[k] == 9999) m_timeout[k] = 1;
      end
    end else if (start) begin
      model_restart(k);
    end
    if (clear_best && !latched) m_best[k] = -1;
  endtask

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) model_reset(k);
      else model_step(k);
    end
  end

  function automatic logic [19:0] codes(input int v);
    if (v < 0) return BLANK4;
    return {5'(v / 1000 % 10), 5'(v / 100 % 10), 5'(v / 10 % 10), 5'(v % 10)};
  endfunction

  function automatic logic [43:0] pack_model(input int k);
    return {m_phase[k] == 1, m_valid[k], m_newbest[k], m_timeout[k],
            codes(m_result[k]), codes(m_best[k])};
  endfunction

  function automatic logic [19:0] dut_res(input int k);
    return {rd[k][3], rd[k][2], rd[k][1], rd[k][0]};
  endfunction

  function automatic logic [19:0] dut_best(input int k);
    return {bd[k][3], bd[k][2], bd[k][1], bd[k][0]};
  endfunction

  function automatic logic [43:0] pack_dut(input int k);
    return {running_o[k], valid_o[k], newbest_o[k], timeout_o[k], dut_res(k), dut_best(k)};
  endfunction

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (check_en) begin
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (pack_dut(k) !== pack_model(k)) begin
          n_fail++;
          $display("FAIL outputs_cpm%0d t=%0t got=%h expected=%h (run,valid,newbest,timeout,result,best)",
                   m_cpm[k], $time, pack_dut(k), pack_model(k));
        end
      end
    end
  end

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of events starting at the current falling edge.
  task automatic pulse(input bit s, input bit p, input bit a, input bit c);
    start = s; stop = p; abort = a; clear_best = c;
    @(negedge clk);
    start = 0; stop = 0; abort = 0; clear_best = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    check_en = 1'b1;
    check("reset_state", pack_dut(0), {4'b0000, BLANK4, BLANK4});

    // Warm-up run so the asynchronous reset has digits to blank.
    pulse(1, 0, 0, 0); idle(50); pulse(0, 1, 0, 0);
    check("warmup_result", {24'd0, dut_res(0)}, {24'd0, R0050});

    // Reset mid-run at 0123.
    pulse(1, 0, 0, 0); idle(123);
    check("running_before_reset", {43'd0, running_o[0]}, 44'd1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_cpm1", pack_dut(0), {4'b0000, BLANK4, BLANK4});
    check("async_reset_cpm4", pack_dut(1), {4'b0000, BLANK4, BLANK4});
    @(negedge clk);
    reset = 1'b1;
    pulse(0, 1, 0, 0); idle(2);
    check("stop_ignored_idle", pack_dut(0), {4'b0000, BLANK4, BLANK4});

    // First result: 250 ms.
    pulse(1, 0, 0, 0); idle(250); pulse(0, 1, 0, 0);
    check("first_result", pack_dut(0), {4'b0110, R0250, R0250});
    check("model_first_result", pack_model(0), {4'b0110, R0250, R0250});

    // Better, then worse.
    pulse(1, 0, 0, 0); idle(187); pulse(0, 1, 0, 0);
    check("better_result", pack_dut(0), {4'b0110, R0187, R0187});
    pulse(1, 0, 0, 0); idle(300); pulse(0, 1, 0, 0);
    check("worse_result", pack_dut(0), {4'b0100, R0300, R0187});
    check("model_worse_result", pack_model(0), {4'b0100, R0300, R0187});

    // Saturation at 9999.
    pulse(1, 0, 0, 0); idle(10050); pulse(0, 1, 0, 0);
    check("saturation", pack_dut(0), {4'b0101, R9999, R0187});

    // Abort wins over a simultaneous stop.
    pulse(1, 0, 0, 0); idle(40); pulse(0, 1, 1, 0);
    check("abort_priority", pack_dut(0), {4'b0000, BLANK4, R0187});
    idle(2);
    check("abort_stays_idle", pack_dut(0), {4'b0000, BLANK4, R0187});

    // clear_best, then a 40-cycle run (10 ms on the 4-cycle instance).
    pulse(0, 0, 0, 1);
    check("clear_best_cpm1", {24'd0, dut_best(0)}, {24'd0, BLANK4});
    check("clear_best_cpm4", {24'd0, dut_best(1)}, {24'd0, BLANK4});
    pulse(1, 0, 0, 0); idle(40); pulse(0, 1, 0, 0);
    check("prescaled_cpm4", pack_dut(1), {4'b0110, R0010, R0010});
    check("prescaled_cpm1", pack_dut(0), {4'b0110, R0040, R0040});

    // clear_best in the latch cycle: worse result still becomes best.
    pulse(1, 0, 0, 0); idle(500); pulse(0, 1, 0, 1);
    check("clear_on_latch_cpm1", pack_dut(0), {4'b0110, R0500, R0500});
    check("clear_on_latch_cpm4", pack_dut(1), {4'b0110, R0125, R0125});
    check("model_clear_on_latch", pack_model(1), {4'b0110, R0125, R0125});

    // Randomised traffic: a busy phase and a sparse phase with longer runs.
    for (int ph = 0; ph < 2; ph++) begin
      for (int i = 0; i < 4000; i++) begin
        int r;
        int span;
        span = (ph == 0) ? 100 : 1000;
        r = int'($urandom_range(0, span - 1));
        start      = (r < 3);
        stop       = (r >= 3 && r < 8);
        abort      = (r >= 8 && r < 11);
        clear_best = ($urandom_range(0, span - 1) < 2);
        @(negedge clk);
      end
      start = 0; stop = 0; abort = 0; clear_best = 0;
      idle(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
